// File: rtl/cnn_act_pool.sv
// cnn_act_pool: streaming ReLU + requantise + optional 2x2/stride-2 max-pool.
// Raw conv accumulator results arrive in raster order, one channel plane per
// frame. Each output beat carries acti_finish_flag (data valid) and
// pooling_signal (1 = more pixels follow in this output row, 0 = last pixel
// of the output row) for the output address counter downstream.
//
// Handshake: in_valid qualifies in_data for the current cycle; there is no
// ready/backpressure. A beat is accepted only while the FSM is in RUN and
// start is low, and is silently dropped otherwise. acti_finish_flag qualifies
// out_data for exactly one cycle per result; the consumer must always accept.
module cnn_act_pool #(
   parameter int ACC_DW = 20,
   parameter int DW     = 8,
   parameter int MAX_W  = 28,
   parameter int DIM_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     pool_en,
   input  logic [4:0]               shift_amt,
   input  logic [DIM_W-1:0]         in_width,
   input  logic [DIM_W-1:0]         in_height,
   input  logic                     in_valid,
   input  logic signed [ACC_DW-1:0] in_data,
   output logic [DW-1:0]            out_data,
   output logic                     acti_finish_flag,
   output logic                     pooling_signal,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int LB_DEPTH = MAX_W / 2;
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
   localparam logic [DW-1:0]    DW_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // FSM state; kept as a named enum register so checkers can bind to it
   state_t state_q, state_d;
   logic   flush_cnt_q, flush_cnt_d;

   // Latched frame configuration
   logic             pool_q;
   logic [4:0]       shift_q;
   logic [DIM_W-1:0] width_q;
   logic [DIM_W-1:0] height_q;

   // Input position counters
   logic [DIM_W-1:0] col_q;
   logic [DIM_W-1:0] row_q;

   logic             accept;
   logic             last_col;
   logic             last_pix;
   logic [DIM_W-1:0] width_m1;
   logic [DIM_W-1:0] half_m1;

   // Stage 1: activated and requantised pixel plus its input position
   logic signed [ACC_DW-1:0] shifted;
   logic [DW-1:0]            q_d;
   logic                     s1_valid_q;
   logic [DW-1:0]            s1_data_q;
   logic [DIM_W-1:0]         s1_col_q;
   logic                     s1_row_odd_q;

   // Stage 2: pooling datapath
   logic [DW-1:0]    pair_q;
   logic [DW-1:0]    linebuf [LB_DEPTH];
   logic [LB_AW-1:0] lb_idx;
   logic [DW-1:0]    lb_rd;
   logic [DW-1:0]    h_max;
   logic [DW-1:0]    win_max;
   logic             pool_ps;
   logic             byp_ps;
   logic             pair_we;
   logic             lb_we;
   logic             out_valid_d;
   logic [DW-1:0]    out_data_d;
   logic             ps_d;

   assign width_m1 = width_q - DIM_ONE;
   assign half_m1  = (width_q >> 1) - DIM_ONE;
   assign accept   = in_valid && (state_q == RUN) && !start;
   assign last_col = (col_q == width_m1);
   assign last_pix = last_col && (row_q == (height_q - DIM_ONE));

   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == FLUSH) && flush_cnt_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         flush_cnt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // FSM next state: start wins from any state; FLUSH lasts two cycles
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = 1'b0;
      if (start) begin
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
               if (accept && last_pix) begin
                  state_d = FLUSH;
               end
            end
            FLUSH: begin
               if (flush_cnt_q) begin
                  state_d = IDLE;
               end else begin
                  flush_cnt_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Config latch and raster position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pool_q   <= 1'b0;
         shift_q  <= '0;
         width_q  <= '0;
         height_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
      end else if (start) begin
         pool_q   <= pool_en;
         shift_q  <= shift_amt;
         width_q  <= in_width;
         height_q <= in_height;
         col_q    <= '0;
         row_q    <= '0;
      end else if (accept) begin
         if (last_col) begin
            col_q <= '0;
            row_q <= row_q + DIM_ONE;
         end else begin
            col_q <= col_q + DIM_ONE;
         end
      end
   end

   // ReLU, arithmetic right shift, saturate to the unsigned output range
   always_comb begin
      shifted = in_data >>> shift_q;
      if (in_data[ACC_DW-1]) begin
         q_d = '0;
      end else if (|shifted[ACC_DW-1:DW]) begin
         q_d = DW_MAX;
      end else begin
         q_d = shifted[DW-1:0];
      end
   end

   // Stage 1 register; start drops whatever pixel is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_col_q     <= '0;
         s1_row_odd_q <= 1'b0;
      end else if (start) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_data_q    <= q_d;
            s1_col_q     <= col_q;
            s1_row_odd_q <= row_q[0];
         end
      end
   end

   assign lb_idx  = s1_col_q[LB_AW:1];
   assign lb_rd   = linebuf[lb_idx];
   assign h_max   = (s1_data_q > pair_q) ? s1_data_q : pair_q;
   assign win_max = (lb_rd > h_max) ? lb_rd : h_max;
   assign pool_ps = ({1'b0, s1_col_q[DIM_W-1:1]} != half_m1);
   assign byp_ps  = (s1_col_q != width_m1);

   // Stage 2 decode: bypass, hold left pixel, store top-row pair max, or emit window max
   always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = s1_data_q;
      ps_d        = 1'b0;
      pair_we     = 1'b0;
      lb_we       = 1'b0;
      if (s1_valid_q) begin
         if (!pool_q) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_data_q;
            ps_d        = byp_ps;
         end else if (!s1_col_q[0]) begin
            pair_we = 1'b1;
         end else if (!s1_row_odd_q) begin
            lb_we = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_data_d  = win_max;
            ps_d        = pool_ps;
         end
      end
   end

   // Left pixel of the current horizontal pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_q <= '0;
      end else if (pair_we) begin
         pair_q <= s1_data_q;
      end
   end

   // Line buffer of top-row pair maxima; contents need no reset
   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf[lb_idx] <= h_max;
      end
   end

   // Output register; start suppresses the beat of an aborted frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data         <= '0;
         acti_finish_flag <= 1'b0;
         pooling_signal   <= 1'b0;
      end else if (start) begin
         acti_finish_flag <= 1'b0;
         pooling_signal   <= 1'b0;
      end else begin
         acti_finish_flag <= out_valid_d;
         pooling_signal   <= ps_d;
         if (out_valid_d) begin
            out_data <= out_data_d;
         end
      end
   end

endmodule

// File: tb/tb_cnn_act_pool.sv
// tb_cnn_act_pool: table vectors and randomised frames for cnn_act_pool.
// Expected beats (data, pooling_signal, due cycle) are queued as inputs are
// driven and popped by a negedge monitor whenever acti_finish_flag is high.
module tb_cnn_act_pool;

   localparam int ACC_DW = 20;
   localparam int DW     = 8;
   localparam int DIM_W  = 5;
   localparam int EXP_W  = 32 + 1 + DW;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                     start;
   logic                     pool_en;
   logic [4:0]               shift_amt;
   logic [DIM_W-1:0]         in_width;
   logic [DIM_W-1:0]         in_height;
   logic                     in_valid;
   logic signed [ACC_DW-1:0] in_data;
   logic [DW-1:0]            out_data;
   logic                     acti_finish_flag;
   logic                     pooling_signal;
   logic                     busy;
   logic                     frame_done;

   cnn_act_pool #(.ACC_DW(ACC_DW), .DW(DW), .MAX_W(28), .DIM_W(DIM_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .pool_en          (pool_en),
      .shift_amt        (shift_amt),
      .in_width         (in_width),
      .in_height        (in_height),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .out_data         (out_data),
      .acti_finish_flag (acti_finish_flag),
      .pooling_signal   (pooling_signal),
      .busy             (busy),
      .frame_done       (frame_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   int errors = 0;
   int checks = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_e;
   int fd_due = -1;
   bit fd_seen = 1'b0;

   // Frame data and per-frame expected results (filled by tables or model)
   int pix [0:31][0:31];
   int exp_vals[$];
   bit exp_ps[$];

   typedef struct {
      int din;
      int sh;
      int qexp;
   } qvec_t;
   qvec_t qtab [10];

   int byp_exp [8];
   bit byp_psx [8];

   // Monitor: compare every output beat and frame_done pulse against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (acti_finish_flag) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got data=%0d ps=%0d at cycle %0d, required no output",
                        out_data, pooling_signal, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if (out_data !== mon_e[DW-1:0] || pooling_signal !== mon_e[DW] ||
                   cyc != int'(mon_e[EXP_W-1:DW+1])) begin
                  errors++;
                  $display("FAIL out_beat: got data=%0d ps=%0d cycle=%0d, required data=%0d ps=%0d cycle=%0d",
                           out_data, pooling_signal, cyc, mon_e[DW-1:0], mon_e[DW],
                           int'(mon_e[EXP_W-1:DW+1]));
               end
            end
         end else if (pooling_signal !== 1'b0) begin
            errors++;
            $display("FAIL idle_ps: got pooling_signal=%0d with flag low at cycle %0d, required 0",
                     pooling_signal, cyc);
         end
         if (frame_done) begin
            checks++;
            fd_seen = 1'b1;
            if (cyc != fd_due) begin
               errors++;
               $display("FAIL frame_done_timing: got pulse at cycle %0d, required cycle %0d", cyc, fd_due);
            end
         end
      end
   end

   function automatic int quant(input int x, input int sh);
      int v;
      if (x < 0) return 0;
      v = x >>> sh;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Golden model: expected beats of a frame held in pix
   task automatic model_expect(input int w, input int h, input bit pool, input int sh);
      int m;
      if (!pool) begin
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
               exp_vals.push_back(quant(pix[r][c], sh));
               exp_ps.push_back(c != w - 1);
            end
      end else begin
         for (int pr = 0; pr < h / 2; pr++)
            for (int pc = 0; pc < w / 2; pc++) begin
               m = max2(max2(quant(pix[2*pr][2*pc], sh), quant(pix[2*pr][2*pc+1], sh)),
                        max2(quant(pix[2*pr+1][2*pc], sh), quant(pix[2*pr+1][2*pc+1], sh)));
               exp_vals.push_back(m);
               exp_ps.push_back(pc != w / 2 - 1);
            end
      end
   endtask

   // Driver tasks
   task automatic push_exp(input int val, input bit ps, input int due);
      exp_q.push_back({32'(due), ps, DW'(val)});
   endtask

   task automatic drive_beat(input int d);
      in_valid = 1'b1;
      in_data  = ACC_DW'(d);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ACC_DW'($urandom);
   endtask

   task automatic start_frame(input int w, input int h, input bit pool, input int sh);
      start     = 1'b1;
      pool_en   = pool;
      shift_amt = 5'(sh);
      in_width  = DIM_W'(w);
      in_height = DIM_W'(h);
      @(posedge clk); #1;
      start     = 1'b0;
      pool_en   = ~pool;
      shift_amt = 5'($urandom_range(0, 31));
      in_width  = DIM_W'($urandom_range(0, 31));
      in_height = DIM_W'($urandom_range(0, 31));
      fd_seen   = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input bit pool, input int sh, input int gap_max);
      int n;
      bit is_out;
      start_frame(w, h, pool, sh);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            n = $urandom_range(0, gap_max);
            repeat (n) begin
               in_data = ACC_DW'($urandom);
               @(posedge clk); #1;
            end
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_run: got busy=%0d before beat r%0d c%0d, required 1", busy, r, c);
            end
            is_out = pool ? (r[0] && c[0]) : 1'b1;
            if (is_out && exp_vals.size() > 0)
               push_exp(exp_vals.pop_front(), exp_ps.pop_front(), cyc + 2);
            if (r == h - 1 && c == w - 1) fd_due = cyc + 2;
            drive_beat(pix[r][c]);
         end
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fd_seen && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL frame_end: got fd_seen=%0d pending=%0d, required pulse and 0 pending",
                  fd_seen, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle: got busy=%0d after frame, required 0", busy);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      if (out_data !== '0 || acti_finish_flag !== 1'b0 || pooling_signal !== 1'b0 ||
          busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s: got data=%0d flag=%0d ps=%0d busy=%0d fd=%0d, required all 0",
                  tag, out_data, acti_finish_flag, pooling_signal, busy, frame_done);
      end
   endtask

   task automatic rand_frame(input int w, input int h);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            pix[r][c] = int'($urandom_range(0, 1000)) - 300;
   endtask

   // Stimulus and final report
   initial begin
      qtab[0] = '{-100, 0, 0};
      qtab[1] = '{4096, 2, 255};
      qtab[2] = '{1000, 3, 125};
      qtab[3] = '{255, 0, 255};
      qtab[4] = '{256, 0, 255};
      qtab[5] = '{-1, 5, 0};
      qtab[6] = '{7, 1, 3};
      qtab[7] = '{-524288, 0, 0};
      qtab[8] = '{524287, 19, 0};
      qtab[9] = '{524287, 12, 127};
      byp_exp = '{0, 1, 2, 3, 4, 5, 6, 7};
      byp_psx = '{1, 1, 1, 0, 1, 1, 1, 0};

      rst_n = 1'b0; start = 1'b0; pool_en = 1'b0; shift_amt = '0;
      in_width = '0; in_height = '0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Bypass 4x2, inputs 0..7, then beats during FLUSH/IDLE must be dropped
      for (int i = 0; i < 8; i++) begin
         pix[i / 4][i % 4] = i;
         exp_vals.push_back(byp_exp[i]);
         exp_ps.push_back(byp_psx[i]);
      end
      run_frame(4, 2, 1'b0, 0, 0);
      repeat (4) drive_beat(int'($urandom_range(0, 200)));
      wait_done();

      // Pool 4x2 hand window
      pix[0][0] = 1; pix[0][1] = 5; pix[0][2] = 2; pix[0][3] = 3;
      pix[1][0] = 4; pix[1][1] = 0; pix[1][2] = 9; pix[1][3] = -7;
      exp_vals.push_back(5); exp_ps.push_back(1'b1);
      exp_vals.push_back(9); exp_ps.push_back(1'b0);
      run_frame(4, 2, 1'b1, 0, 0);
      wait_done();

      // Quantisation table as 1x1 bypass frames
      for (int i = 0; i < 10; i++) begin
         pix[0][0] = qtab[i].din;
         exp_vals.push_back(qtab[i].qexp);
         exp_ps.push_back(1'b0);
         run_frame(1, 1, 1'b0, qtab[i].sh, 1);
         wait_done();
      end

      // Odd-size pooled frames with input gaps
      rand_frame(5, 3);
      model_expect(5, 3, 1'b1, 0);
      run_frame(5, 3, 1'b1, 0, 3);
      wait_done();
      rand_frame(7, 5);
      model_expect(7, 5, 1'b1, 1);
      run_frame(7, 5, 1'b1, 1, 2);
      wait_done();

      // Degenerate pooled frames: no output, frame_done still pulses
      rand_frame(1, 3);
      run_frame(1, 3, 1'b1, 0, 1);
      wait_done();
      rand_frame(4, 1);
      run_frame(4, 1, 1'b1, 0, 1);
      wait_done();

      // Random bypass with gaps and shift
      rand_frame(6, 3);
      model_expect(6, 3, 1'b0, 1);
      run_frame(6, 3, 1'b0, 1, 2);
      wait_done();

      // Abort: 6 beats of a 4x4 pooled frame, then restart immediately
      start_frame(4, 4, 1'b1, 0);
      for (int i = 0; i < 6; i++) drive_beat(int'($urandom_range(0, 250)));
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_abort: got busy=%0d before restart, required 1", busy);
      end
      rand_frame(4, 4);
      model_expect(4, 4, 1'b1, 0);
      run_frame(4, 4, 1'b1, 0, 1);
      wait_done();

      // Reset mid-frame with beats still in the pipeline
      start_frame(4, 4, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i < 2) push_exp(i + 10, 1'b1, cyc + 2);
         drive_beat(i + 10);
      end
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("reset_midframe");
      exp_q.delete();
      fd_due = -1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) drive_beat(int'($urandom_range(0, 200)));
      repeat (3) @(posedge clk);
      #1 check_zero_outputs("idle_after_reset");

      // Recovery frame after reset
      rand_frame(3, 2);
      model_expect(3, 2, 1'b0, 0);
      run_frame(3, 2, 1'b0, 0, 1);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cnn_act_pool.md
Name: cnn_act_pool

Overview:
- Streaming ReLU + requantise + 2x2/stride-2 max-pool stage that takes raw conv accumulator results in raster order, one channel plane at a time.
- Emits one 8-bit result per beat with the acti_finish_flag / pooling_signal pair expected by the output address counter directly downstream.
- A beat with pooling_signal=1 advances the downstream RAM-bank index. A beat with pooling_signal=0 marks the last pixel of an output row.
- With pool_en=0 the block is a pure activation stage.

Parameters:
- ACC_DW, 20, signed accumulator width of in_data
- DW, 8, unsigned activation width of out_data
- MAX_W, 28, maximum conv output row width; the line buffer holds MAX_W/2 entries of DW bits
- DIM_W, 5, width of the in_width / in_height config fields

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config and clears all counters
- pool_en  in  1  1 = 2x2 max-pool, 0 = bypass pooling
- shift_amt  in  5  requantisation arithmetic right shift
- in_width  in  DIM_W  conv output columns per row (1..MAX_W)
- in_height  in  DIM_W  conv output rows per plane (1..31)
- in_valid  in  1  in_data valid this cycle; no backpressure
- in_data  in  ACC_DW  signed accumulator result
- out_data  out  DW  activated (and pooled) pixel
- acti_finish_flag  out  1  out_data valid
- pooling_signal  out  1  1 = not last pixel of output row; 0 = last pixel of output row
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of plane

Behaviour:
- Reset: all outputs 0; column/row counters 0; pool_en/width/height/shift registers 0; FSM in IDLE. Line buffer contents are don't-care.
- FSM states:
  - IDLE: in_valid is ignored.
  - RUN: entered the cycle after start.
  - FLUSH: entered after the last input pixel (col = in_width-1, row = in_height-1); lasts 2 cycles, then returns to IDLE.
- start in any state, including mid-frame: re-latches config, clears counters and the pipeline valid bits, and enters RUN. No output is produced from the aborted frame after start.
- busy = 1 in RUN and FLUSH.
- frame_done: pulses on the last FLUSH cycle, i.e. 2 cycles after the last input beat. This coincides with the final output beat when that beat exists.
- Stage 1 (registered, 1 cycle):
  - q = in_data < 0 ? 0 : in_data >>> shift_amt.
  - If q > 2^DW-1, saturate to 2^DW-1.
- Stage 2, pool_en=0:
  - Stage-1 result goes to out_data with acti_finish_flag=1.
  - pooling_signal = (col != in_width-1).
  - Latency is 2 cycles from in_valid.
- Stage 2, pool_en=1, col/row taken from the pixel's input position:
  - Even col: hold the value in the pair register.
  - Odd col: h = max(pair, value).
  - Even row: linebuf[col>>1] <= h; no output.
  - Odd row: out_data <= max(linebuf[col>>1], h); acti_finish_flag=1; pooling_signal = (col>>1 != (in_width>>1)-1).
  - Output appears 2 cycles after the bottom-right pixel of the window.
- Odd dimensions with pool_en=1: floor semantics.
  - Last column of each row is consumed but never pooled.
  - Last row of an odd-height plane is consumed with no output; its writes to linebuf are harmless.
  - in_width=1 or in_height=1: zero outputs, frame_done still pulses.
- Counters: col wraps to 0 at in_width-1 and increments row. Input beats arriving during FLUSH or IDLE are dropped.
- Non-valid cycles: acti_finish_flag=0 and pooling_signal=0. Gaps in in_valid do not affect the result.

Test Plan:
- Bypass, width=4, height=2, shift=0, inputs 0..7:
  - 8 beats out_data 0..7, each 2 cycles after its input.
  - pooling_signal pattern 1,1,1,0,1,1,1,0; frame_done with the 8th beat.
- Pool, width=4, height=2, row0 = {1,5,2,3}, row1 = {4,0,9,-7}, shift=0:
  - Two beats, out_data 5 (pooling_signal=1) then 9 (pooling_signal=0).
  - Second beat arrives 2 cycles after the -7 input.
- Quantisation: in_data = -100 → 0; in_data = 4096 with shift=2 → 255 (saturated); in_data = 1000 with shift=3 → 125.
- Pool, width=5, height=3, random data with in_valid gaps: exactly 2 outputs, matching the golden max of the top-left 4x2 region; frame_done 2 cycles after the 15th input.
- start asserted mid-frame (after 6 inputs of a 4x4 pool frame), then a full new 4x4 frame:
  - No stale outputs.
  - Exactly 4 outputs from the new frame; busy stays high throughout.
- rst_n asserted mid-frame: all outputs 0 immediately, FSM in IDLE; subsequent in_valid is ignored until start.
